spi_lcd_fill: RTL

- Downstream neighbour of the LCD init sequencer; started once init reports done.
- Paints a rectangular window of the ILI9341-class SPI LCD in one solid RGB565 colour.
- Issues CASET, PASET and RAMWR, then streams the colour once per pixel.
- Contains its own byte serializer, same wire protocol as the init path (mosi/dc/cs; SCK = i_clk forwarded at board level, sampled by panel on rising edge).

---
 rtl/spi_lcd_fill_if.sv | 28 ++
 rtl/spi_lcd_fill.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_lcd_fill_if.sv
// Bus bundle for spi_lcd_fill: the start request with its window and colour,
// and the serial LCD wires plus status back to the controller.
//   master : drives i_start/i_x0/i_x1/i_y0/i_y1/i_color, observes the rest
//   slave  : the fill engine
interface spi_lcd_fill_if;
  logic        i_start;
  logic [15:0] i_x0;
  logic [15:0] i_x1;
  logic [15:0] i_y0;
  logic [15:0] i_y1;
  logic [15:0] i_color;
  logic        o_mosi;
  logic        o_dc;
  logic        o_cs;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  modport master (
    output i_start, i_x0, i_x1, i_y0, i_y1, i_color,
    input  o_mosi, o_dc, o_cs, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_x0, i_x1, i_y0, i_y1, i_color,
    output o_mosi, o_dc, o_cs, o_busy, o_done, o_err
  );
endinterface

// File: rtl/spi_lcd_fill.sv
// spi_lcd_fill: paints a rectangular window of an ILI9341-class SPI LCD in one
// RGB565 colour. Sends CASET (x0,x1), PASET (y0,y1), RAMWR, then the colour
// once per pixel, through a built-in byte serializer (CS low 8 cycles per
// byte, MSB first, CS high CS_GAP cycles between bytes).
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : i_start + window/colour in; o_mosi/o_dc/o_cs to the panel;
//                  o_busy, o_done (completion pulse), o_err (rejected window)
// Build option: define LCD_FILL_CLIP_EN to clamp x1/y1 to the panel size
// (WIDTH, HEIGHT) and reject windows that start outside the panel.
module spi_lcd_fill #(
  parameter int CS_GAP = 1,
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic          i_clk,
  input  logic          i_rst,
  spi_lcd_fill_if.slave bus
);
  if (CS_GAP < 1 || CS_GAP > 15 || WIDTH < 1 || WIDTH > 65535 ||
      HEIGHT < 1 || HEIGHT > 65535) begin : g_bad_param
    $error("spi_lcd_fill: parameter out of range");
  end

  typedef enum logic [3:0] {
    IDLE, LOAD, CASET, XDATA, PASET, YDATA, RAMWR, PIX, FIN
  } state_t;

  state_t      state, nstate;
  logic [15:0] x0, x1, y0, y1, color;
  logic [31:0] cnt;
  logic [1:0]  idx;      // byte index inside XDATA/YDATA
  logic        ph;       // 0: colour high byte next, 1: low byte next
  logic        bad, done, err, ld, tx_dc;
  logic [7:0]  tx_byte;
  logic [15:0] wsel;
  logic [16:0] wx, wy;
  logic [33:0] npix;

  // serializer state
  logic [7:0]  sh;
  logic [2:0]  bcnt;
  logic [3:0]  gap;
  logic        cs_q, mosi_q, dc_q, rdy;

  // window latch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x0 <= '0; x1 <= '0; y0 <= '0; y1 <= '0; color <= '0;
    end else if (state == IDLE && bus.i_start) begin
      x0    <= bus.i_x0;
      y0    <= bus.i_y0;
      color <= bus.i_color;
`ifdef LCD_FILL_CLIP_EN
      x1 <= (bus.i_x1 > 16'(WIDTH - 1))  ? 16'(WIDTH - 1)  : bus.i_x1;
      y1 <= (bus.i_y1 > 16'(HEIGHT - 1)) ? 16'(HEIGHT - 1) : bus.i_y1;
`else
      x1 <= bus.i_x1;
      y1 <= bus.i_y1;
`endif
    end
  end

  always_comb begin
    bad = (x1 < x0) || (y1 < y0);
`ifdef LCD_FILL_CLIP_EN
    if (x0 >= 16'(WIDTH) || y0 >= 16'(HEIGHT)) bad = 1'b1;
`endif
  end

  // 65536 x 65536 needs bit 32; truncation leaves 0, which the counter
  // treats as 2^32 because it only exits on the 1 -> 0 step.
  assign wx   = {1'b0, x1} - {1'b0, x0} + 17'd1;
  assign wy   = {1'b0, y1} - {1'b0, y0} + 17'd1;
  assign npix = 34'(wx) * 34'(wy);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate  = state;
    ld      = 1'b0;
    tx_byte = 8'h00;
    tx_dc   = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    wsel    = 16'h0000;
    case (state)
      IDLE:  if (bus.i_start) nstate = LOAD;
      LOAD: begin
        if (bad) begin
          done   = 1'b1;
          err    = 1'b1;
          nstate = IDLE;
        end else begin
          nstate = CASET;
        end
      end
      CASET, PASET, RAMWR: begin
        tx_dc   = 1'b0;
        tx_byte = (state == CASET) ? 8'h2A : (state == PASET) ? 8'h2B : 8'h2C;
        if (rdy) begin
          ld     = 1'b1;
          nstate = (state == CASET) ? XDATA : (state == PASET) ? YDATA : PIX;
        end
      end
      XDATA, YDATA: begin
        if (state == XDATA) wsel = idx[1] ? x1 : x0;
        else                wsel = idx[1] ? y1 : y0;
        tx_byte = idx[0] ? wsel[7:0] : wsel[15:8];
        if (rdy) begin
          ld = 1'b1;
          if (idx == 2'd3) nstate = (state == XDATA) ? PASET : RAMWR;
        end
      end
      PIX: begin
        tx_byte = ph ? color[7:0] : color[15:8];
        if (rdy) begin
          ld = 1'b1;
          if (ph && cnt == 32'd1) nstate = FIN;
        end
      end
      FIN: begin
        // wait for the last byte to leave the wire
        if (cs_q) begin
          done   = 1'b1;
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      idx <= '0;
      ph  <= 1'b0;
    end else if (state == LOAD) begin
      cnt <= npix[31:0];
      idx <= '0;
      ph  <= 1'b0;
    end else if (ld) begin
      if (state == XDATA || state == YDATA) idx <= idx + 2'd1;
      if (state == PIX) begin
        ph <= ~ph;
        if (ph) cnt <= cnt - 32'd1;
      end
    end
  end

  // Byte serializer. Ready on the last gap cycle so the next byte's CS
  // falls right after exactly CS_GAP high cycles.
  assign rdy = cs_q && (gap <= 4'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_q   <= 1'b1;
      mosi_q <= 1'b0;
      dc_q   <= 1'b0;
      sh     <= '0;
      bcnt   <= '0;
      gap    <= '0;
    end else if (ld) begin
      cs_q   <= 1'b0;
      mosi_q <= tx_byte[7];
      sh     <= {tx_byte[6:0], 1'b0};
      dc_q   <= tx_dc;
      bcnt   <= 3'd7;
    end else if (!cs_q) begin
      if (bcnt == 3'd0) begin
        cs_q   <= 1'b1;
        mosi_q <= 1'b0;
        gap    <= 4'(CS_GAP);
      end else begin
        mosi_q <= sh[7];
        sh     <= {sh[6:0], 1'b0};
        bcnt   <= bcnt - 3'd1;
      end
    end else if (gap != 4'd0) begin
      gap <= gap - 4'd1;
    end
  end

  assign bus.o_cs   = cs_q;
  assign bus.o_mosi = mosi_q;
  assign bus.o_dc   = dc_q;
  assign bus.o_done = done;
  assign bus.o_err  = err;
  assign bus.o_busy = (state != IDLE) && !done;
endmodule
